// File: rtl/qr_givens_sched.sv
// Givens-rotation schedule controller for the QR-CORDIC datapath: copies the
// source matrix from ROM into the working RAM, then runs every rotation in place.
module qr_givens_sched #(
  parameter int WIDTH  = 13,
  parameter int ROWS   = 8,
  parameter int COLS   = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ori_rd,
  output logic [ADDR_W-1:0] ori_addr,
  input  logic [WIDTH-1:0]  ori_di,
  output logic              matr_rd,
  output logic [ADDR_W-1:0] matr_rd_addr,
  input  logic [WIDTH-1:0]  matr_di,
  output logic              matr_wr,
  output logic [ADDR_W-1:0] matr_wr_addr,
  output logic [WIDTH-1:0]  matr_do,
  output logic              cd_valid,
  input  logic              cd_ready,
  output logic              cd_mode,
  output logic [WIDTH-1:0]  cd_x,
  output logic [WIDTH-1:0]  cd_y,
  input  logic              cd_res_valid,
  input  logic [WIDTH-1:0]  cd_res_x,
  input  logic [WIDTH-1:0]  cd_res_y
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int NELEM = ROWS * COLS;
  localparam int NW    = $clog2(NELEM) + 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_COPY  = 4'd1;
  localparam logic [3:0] S_RD_X  = 4'd2;
  localparam logic [3:0] S_RD_Y  = 4'd3;
  localparam logic [3:0] S_ISSUE = 4'd4;
  localparam logic [3:0] S_WAIT  = 4'd5;
  localparam logic [3:0] S_WR_X  = 4'd6;
  localparam logic [3:0] S_WR_Y  = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  logic [3:0]        r_state;
  logic [NW-1:0]     r_n;
  logic [CW-1:0]     r_j;
  logic [RW-1:0]     r_i;
  logic [CW-1:0]     r_k;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic [WIDTH-1:0]  r_res_y;

  logic [CW-1:0]     w_nj;
  logic [RW-1:0]     w_ni;
  logic [CW-1:0]     w_nk;
  logic              w_last;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_next_a;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [RW-1:0] row,
                                               input logic [CW-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  // Loop nest: k innermost (j..COLS-1), then i (ROWS-1 down to j+1), then j.
  always_comb begin
    w_nj   = r_j;
    w_ni   = r_i;
    w_nk   = r_k;
    w_last = 1'b0;
    if (r_k != CW'(COLS - 1)) begin
      w_nk = r_k + CW'(1);
    end else if (r_i != RW'(r_j) + RW'(1)) begin
      w_ni = r_i - RW'(1);
      w_nk = r_j;
    end else if (r_j != CW'(COLS - 1)) begin
      w_nj = r_j + CW'(1);
      w_ni = RW'(ROWS - 1);
      w_nk = r_j + CW'(1);
    end else begin
      w_last = 1'b1;
    end
  end

  always_comb begin
    w_addr_a = f_addr(r_i - RW'(1), r_k);
    w_addr_b = f_addr(r_i, r_k);
    w_next_a = f_addr(w_ni - RW'(1), w_nk);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_j          <= '0;
      r_i          <= '0;
      r_k          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_res_y      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ori_rd       <= 1'b0;
      ori_addr     <= '0;
      matr_rd      <= 1'b0;
      matr_rd_addr <= '0;
      matr_wr      <= 1'b0;
      matr_wr_addr <= '0;
      matr_do      <= '0;
      cd_valid     <= 1'b0;
      cd_mode      <= 1'b0;
      cd_x         <= '0;
      cd_y         <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_COPY;
            done     <= 1'b0;
            busy     <= 1'b1;
            r_n      <= '0;
            ori_rd   <= 1'b1;
            ori_addr <= '0;
          end
        end
        // ROM read of word n overlaps the RAM write of word n-1.
        S_COPY: begin
          r_n    <= r_n + NW'(1);
          ori_rd <= (r_n < NW'(NELEM - 1));
          if (r_n < NW'(NELEM - 1))
            ori_addr <= ADDR_W'(r_n + NW'(1));
          if (r_n == NW'(NELEM)) begin
            matr_wr      <= 1'b0;
            r_state      <= S_RD_X;
            r_j          <= '0;
            r_i          <= RW'(ROWS - 1);
            r_k          <= '0;
            matr_rd      <= 1'b1;
            matr_rd_addr <= f_addr(RW'(ROWS - 2), '0);
          end else begin
            matr_wr      <= 1'b1;
            matr_wr_addr <= ADDR_W'(r_n);
            matr_do      <= ori_di;
          end
        end
        S_RD_X: begin
          r_x          <= matr_di;
          matr_rd_addr <= w_addr_b;
          r_state      <= S_RD_Y;
        end
        S_RD_Y: begin
          r_y     <= matr_di;
          matr_rd <= 1'b0;
          r_state <= S_ISSUE;
        end
        // First ISSUE cycle loads the operand registers; the request is held after.
        S_ISSUE: begin
          if (!cd_valid) begin
            cd_valid <= 1'b1;
            cd_x     <= r_x;
            cd_y     <= r_y;
            cd_mode  <= (r_k != r_j);
          end else if (cd_ready) begin
            cd_valid <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cd_res_valid) begin
            r_res_y      <= cd_res_y;
            matr_wr      <= 1'b1;
            matr_wr_addr <= w_addr_a;
            matr_do      <= cd_res_x;
            r_state      <= S_WR_X;
          end
        end
        S_WR_X: begin
          matr_wr_addr <= w_addr_b;
          matr_do      <= cd_mode ? r_res_y : '0;
          r_state      <= S_WR_Y;
        end
        S_WR_Y: begin
          matr_wr <= 1'b0;
          r_j     <= w_nj;
          r_i     <= w_ni;
          r_k     <= w_nk;
          if (w_last) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state      <= S_RD_X;
            matr_rd      <= 1'b1;
            matr_rd_addr <= w_next_a;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qr_givens_sched.sv
// Bench for qr_givens_sched: ROM/RAM/CORDIC-engine models, a reference schedule
// model feeding an operand scoreboard, and a table of full runs.
module tb_qr_givens_sched;
  localparam int W  = 13;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, ori_rd, matr_rd, matr_wr, cd_valid, cd_mode;
  logic [AW-1:0] ori_addr, matr_rd_addr, matr_wr_addr;
  logic [W-1:0]  ori_di, matr_di, matr_do, cd_x, cd_y, cd_res_x, cd_res_y;
  logic          cd_ready, cd_res_valid;

  qr_givens_sched #(.WIDTH(W), .ROWS(8), .COLS(4), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ori_rd(ori_rd), .ori_addr(ori_addr), .ori_di(ori_di),
    .matr_rd(matr_rd), .matr_rd_addr(matr_rd_addr), .matr_di(matr_di),
    .matr_wr(matr_wr), .matr_wr_addr(matr_wr_addr), .matr_do(matr_do),
    .cd_valid(cd_valid), .cd_ready(cd_ready), .cd_mode(cd_mode),
    .cd_x(cd_x), .cd_y(cd_y), .cd_res_valid(cd_res_valid),
    .cd_res_x(cd_res_x), .cd_res_y(cd_res_y)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] x; logic [W-1:0] y; logic mode; } op_t;
  typedef struct {
    int rom_sel; int eng_sel; int rdy; int lmin; int lmax;
    int spur; int poke; int exp_cyc; int exp_hs; int exp_m0;
  } run_t;

  logic [W-1:0] rom [32];
  logic [W-1:0] ram [32];
  logic [W-1:0] exp_ram [32];
  op_t          sb [$];

  int n_checks = 0;
  int n_errors = 0;
  int hs_count, m0_count;
  int e_sel, e_rdy, e_lmin, e_lmax, e_spur;

  // Memories update read data / commit writes on the falling edge.
  always @(negedge clk) begin
    if (ori_rd) ori_di <= rom[ori_addr];
    if (matr_rd) matr_di <= ram[matr_rd_addr];
    if (matr_wr) ram[matr_wr_addr] <= matr_do;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({busy, done, ori_rd, ori_addr, matr_rd, matr_rd_addr, matr_wr,
                matr_wr_addr, matr_do, cd_valid, cd_mode, cd_x, cd_y});
  endfunction

  function automatic void eng(input int sel, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic m, output logic [W-1:0] rx, output logic [W-1:0] ry);
    if (sel == 0) begin
      rx = x; ry = y;
    end else if (!m) begin
      rx = x + y; ry = 13'h0055;
    end else begin
      rx = x - y; ry = y + {x[W-2:0], 1'b0};
    end
  endfunction

  task automatic gen_golden(input int sel);
    logic [W-1:0] m [32];
    logic [W-1:0] rx, ry;
    op_t o;
    int a, b;
    for (int n = 0; n < 32; n++) m[n] = rom[n];
    sb.delete();
    for (int j = 0; j < 4; j++)
      for (int i = 7; i > j; i--)
        for (int k = j; k < 4; k++) begin
          a = (i - 1) * 4 + k;
          b = i * 4 + k;
          o.x = m[a]; o.y = m[b]; o.mode = (k != j);
          sb.push_back(o);
          eng(sel, o.x, o.y, o.mode, rx, ry);
          m[a] = rx;
          m[b] = o.mode ? ry : '0;
        end
    for (int n = 0; n < 32; n++) exp_ram[n] = m[n];
  endtask

  // CORDIC engine model: decides cd_ready/cd_res_valid each cycle at the falling edge.
  initial begin : engine
    logic         pend, pv, pr, pm;
    logic [W-1:0] px, py, rx, ry;
    int           pcnt;
    op_t          e;
    pend = 0; pv = 0; pr = 0; pm = 0; px = '0; py = '0; pcnt = 0;
    cd_ready = 0; cd_res_valid = 0; cd_res_x = '0; cd_res_y = '0;
    forever begin
      @(negedge clk);
      cd_res_valid = 0;
      if (!reset) begin
        pend = 0; pv = 0; cd_ready = 0;
      end else begin
        if (pv && !pr)
          check("stall_hold", 64'({cd_valid, cd_mode, cd_x, cd_y}), 64'({1'b1, pm, px, py}));
        if (pend) begin
          if (pcnt <= 1) begin
            cd_res_valid = 1; cd_res_x = rx; cd_res_y = ry; pend = 0;
          end else pcnt--;
        end else if (e_spur != 0 && $urandom_range(0, 1) == 1) begin
          cd_res_valid = 1; cd_res_x = 13'h1abc; cd_res_y = 13'h0f0f;
        end
        case (e_rdy)
          0:       cd_ready = 1;
          1:       cd_ready = ($urandom_range(0, 99) < 30);
          default: cd_ready = 0;
        endcase
        if (cd_valid && cd_ready) begin
          hs_count++;
          if (!cd_mode) m0_count++;
          if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_underflow: got handshake %0d expected none", hs_count);
          end else begin
            e = sb.pop_front();
            check("op_x", 64'(cd_x), 64'(e.x));
            check("op_y", 64'(cd_y), 64'(e.y));
            check("op_mode", 64'(cd_mode), 64'(e.mode));
          end
          eng(e_sel, cd_x, cd_y, cd_mode, rx, ry);
          pend = 1;
          pcnt = $urandom_range(e_lmin, e_lmax);
        end
        pv = cd_valid; pr = cd_ready; pm = cd_mode; px = cd_x; py = cd_y;
      end
    end
  end

  task automatic load_rom(input int sel);
    for (int n = 0; n < 32; n++)
      case (sel)
        0:       rom[n] = W'(n);
        1:       rom[n] = W'($urandom);
        default: rom[n] = W'(n * 517) ^ 13'h1555;
      endcase
  endtask

  // Called right after a falling edge. Start is driven in cycle 1.
  task automatic do_run(input run_t r, input bit abort);
    int cyc;
    bit fin;
    load_rom(r.rom_sel);
    gen_golden(r.eng_sel);
    e_sel = r.eng_sel; e_rdy = r.rdy; e_lmin = r.lmin; e_lmax = r.lmax; e_spur = r.spur;
    hs_count = 0; m0_count = 0;
    start = 1; cyc = 1; fin = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (r.poke != 0 && (cyc == 5 || cyc == 100 || cyc == 300)) start = 1;
      if (r.poke != 0 && hs_count == 60 && matr_wr && matr_wr_addr == 5'd19) start = 1;
      if (cyc == 2) check("start_busy_done", 64'({busy, done}), 64'(2'b10));
      if (abort && hs_count == 10 && matr_rd) begin
        reset = 0;
        #1;
        check("abort_outs_zero", outs(), 64'(0));
        return;
      end
      if (done) fin = 1;
      else if (cyc > 5000) begin
        n_checks++; n_errors++;
        $display("FAIL done_timeout: got no done by cycle %0d expected done", cyc);
        fin = 1;
      end
    end
    start = 0;
    if (r.exp_cyc > 0) check("done_cycle", 64'(cyc), 64'(r.exp_cyc));
    check("handshakes", 64'(hs_count), 64'(r.exp_hs));
    check("mode0_count", 64'(m0_count), 64'(r.exp_m0));
    check("sb_left", 64'(sb.size()), 64'(0));
    check("busy_at_done", 64'(busy), 64'(0));
    for (int n = 0; n < 32; n++) check($sformatf("ram[%0d]", n), 64'(ram[n]), 64'(exp_ram[n]));
    if (r.poke != 0)
      repeat (3) begin
        @(negedge clk);
        check("late_start_ignored", 64'({busy, done}), 64'(2'b01));
      end
  endtask

  run_t runs [5];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic exp_rd, exp_wr;
    runs[0] = '{0, 0, 0, 1, 1, 0, 0, 455, 60, 22};
    runs[1] = '{1, 1, 0, 1, 1, 1, 1, 455, 60, 22};
    runs[2] = '{0, 1, 1, 1, 5, 1, 0, 0,   60, 22};
    runs[3] = '{2, 1, 0, 3, 3, 0, 0, 575, 60, 22};
    runs[4] = '{0, 0, 0, 1, 1, 0, 0, 455, 60, 22};
    e_sel = 0; e_rdy = 2; e_lmin = 1; e_lmax = 1; e_spur = 0;
    hs_count = 0; m0_count = 0;
    reset = 0; start = 0;
    repeat (3) @(negedge clk);
    check("reset_outs_zero", outs(), 64'(0));
    reset = 1;
    @(negedge clk);

    // Copy with a stalled engine.
    load_rom(0);
    gen_golden(0);
    e_rdy = 2;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int t = 0; t <= 33; t++) begin
      exp_rd = (t <= 31);
      exp_wr = (t >= 1 && t <= 32);
      check("copy_ori_rd", 64'(ori_rd), 64'(exp_rd));
      if (exp_rd) check("copy_ori_addr", 64'(ori_addr), 64'(t));
      check("copy_wr", 64'(matr_wr), 64'(exp_wr));
      if (exp_wr) begin
        check("copy_wr_addr", 64'(matr_wr_addr), 64'(t - 1));
        check("copy_wr_data", 64'(matr_do), 64'(rom[t - 1]));
      end
      if (t == 0) check("copy_busy_done", 64'({busy, done}), 64'(2'b10));
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    for (int n = 0; n < 32; n++) check($sformatf("copy_ram[%0d]", n), 64'(ram[n]), 64'(n));
    check("stalled_state", 64'({busy, done, cd_valid}), 64'(3'b101));
    reset = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    for (int r = 0; r < 5; r++) do_run(runs[r], 1'b0);

    // Abort during operation 10, then a clean rerun.
    do_run(runs[3], 1'b1);
    repeat (3) @(negedge clk);
    check("abort_held_zero", outs(), 64'(0));
    reset = 1;
    @(negedge clk);
    do_run(runs[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
